// File: rtl/led_status_sequencer_if.sv
// Status-LED sequencer bus: request/enable inputs and LED/status outputs.
// Latency: pure wiring, no storage.
// Backpressure: none; requests are levels held by their sources.
interface led_status_sequencer_if;
  logic [3:0] iv_status_req;
  logic       i_led_en;
  logic       o_led;
  logic [1:0] ov_cur_src;
  logic       o_seq_busy;

  // Requesting side: drives the status levels and enable, watches the LED.
  modport master (
    output iv_status_req,
    output i_led_en,
    input  o_led,
    input  ov_cur_src,
    input  o_seq_busy
  );

  // Sequencer side.
  modport slave (
    input  iv_status_req,
    input  i_led_en,
    output o_led,
    output ov_cur_src,
    output o_seq_busy
  );
endinterface

// File: rtl/led_status_sequencer.sv
// Blinks source k as k+1 pulses on one shared LED, round-robin over 4 level requests.
// Latency: LED rises one edge after the request is sampled in IDLE; one IDLE cycle per code.
// Backpressure: none; requests are levels, a request seen mid-code waits for the next IDLE.
module led_status_sequencer #(
  parameter logic [31:0] BLINK_TIME = 32'd12_500_000,
  parameter logic [31:0] GAP_TIME   = 32'd62_500_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  led_status_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] time_cnt_q, time_cnt_d;
  logic [2:0]  blink_cnt_q, blink_cnt_d;
  logic [1:0]  rr_last_q, rr_last_d;
  logic [1:0]  cur_src_q, cur_src_d;
  logic        led_q, led_d;
  logic        busy_q, busy_d;

  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;

  // Round-robin search starting one past the last completed source.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = rr_last_q + 2'(i);
      if (!grant_vld && bus.iv_status_req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic for the blink sequence.
  always_comb begin
    state_d     = state_q;
    time_cnt_d  = time_cnt_q;
    blink_cnt_d = blink_cnt_q;
    rr_last_d   = rr_last_q;
    cur_src_d   = cur_src_q;
    led_d       = led_q;
    busy_d      = busy_q;

    if (state_q != S_IDLE && !bus.i_led_en) begin
      // Disable aborts the code; rr_last is kept so fairness survives the abort.
      state_d     = S_IDLE;
      time_cnt_d  = 32'd0;
      blink_cnt_d = 3'd0;
      led_d       = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          led_d  = 1'b0;
          busy_d = 1'b0;
          if (bus.i_led_en && grant_vld) begin
            cur_src_d   = grant_idx;
            time_cnt_d  = 32'd0;
            blink_cnt_d = 3'd0;
            led_d       = 1'b1;
            busy_d      = 1'b1;
            state_d     = S_ON;
          end
        end
        S_ON: begin
          if (time_cnt_q == BLINK_TIME - 32'd1) begin
            time_cnt_d = 32'd0;
            led_d      = 1'b0;
            state_d    = S_OFF;
          end else begin
            time_cnt_d = time_cnt_q + 32'd1;
          end
        end
        S_OFF: begin
          if (time_cnt_q == BLINK_TIME - 32'd1) begin
            time_cnt_d  = 32'd0;
            blink_cnt_d = blink_cnt_q + 3'd1;
            // Pulses are numbered from 0, so source k stops after pulse k.
            if (blink_cnt_q == {1'b0, cur_src_q}) begin
              state_d = S_GAP;
            end else begin
              led_d   = 1'b1;
              state_d = S_ON;
            end
          end else begin
            time_cnt_d = time_cnt_q + 32'd1;
          end
        end
        S_GAP: begin
          led_d = 1'b0;
          if (time_cnt_q == GAP_TIME - 32'd1) begin
            time_cnt_d = 32'd0;
            rr_last_d  = cur_src_q;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            time_cnt_d = time_cnt_q + 32'd1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          time_cnt_d  = 32'd0;
          blink_cnt_d = 3'd0;
          rr_last_d   = 2'd3;
          cur_src_d   = 2'd0;
          led_d       = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  // State register; reset parks rr_last at 3 so the first search begins at source 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      time_cnt_q  <= 32'd0;
      blink_cnt_q <= 3'd0;
      rr_last_q   <= 2'd3;
      cur_src_q   <= 2'd0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_cnt_q  <= time_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      rr_last_q   <= rr_last_d;
      cur_src_q   <= cur_src_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_led      = led_q;
  assign bus.ov_cur_src = cur_src_q;
  assign bus.o_seq_busy = busy_q;

endmodule

// File: tb/tb_led_status_sequencer.sv
// Directed bench for led_status_sequencer with BLINK_TIME=4, GAP_TIME=8.
// Each expected blink code is queued when stimulus is driven and checked when o_seq_busy falls.
// Outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_led_status_sequencer;

  typedef struct {
    int src;
    int pulses;
    int busy_len;
    int hi_cycles;
    int idle;      // idle cycles before the grant, -1 = not checked
  } seq_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   seq_done;
  seq_t exp_q[$];

  led_status_sequencer_if bus();

  led_status_sequencer #(
    .BLINK_TIME(32'd4),
    .GAP_TIME  (32'd8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic seq_t code(input int src, input int idle);
    seq_t s;
    s.src       = src;
    s.pulses    = src + 1;
    s.busy_len  = 8 * (src + 1) + 8;
    s.hi_cycles = 4 * (src + 1);
    s.idle      = idle;
    return s;
  endfunction

  function automatic seq_t cut(input int src, input int pulses, input int busy_len,
                               input int hi_cycles, input int idle);
    seq_t s;
    s.src       = src;
    s.pulses    = pulses;
    s.busy_len  = busy_len;
    s.hi_cycles = hi_cycles;
    s.idle      = idle;
    return s;
  endfunction

  // Monitor: measures each busy window and compares against the queued expectation.
  logic prev_busy = 1'b0;
  logic prev_led  = 1'b0;
  int   busy_len  = 0;
  int   hi_cycles = 0;
  int   pulses    = 0;
  int   idle_len  = 0;
  seq_t cur;
  always @(negedge clk) begin
    if (bus.o_seq_busy && !prev_busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'd1, 32'd0);
      end else begin
        cur = exp_q[0];
        chk("grant_src", 32'(bus.ov_cur_src), cur.src);
        if (cur.idle >= 0) chk("idle_gap", idle_len, cur.idle);
      end
      busy_len  = 0;
      hi_cycles = 0;
      pulses    = 0;
    end
    if (bus.o_seq_busy) begin
      busy_len++;
      if (bus.o_led) hi_cycles++;
      if (bus.o_led && !prev_led) pulses++;
      idle_len = 0;
    end else begin
      chk("led_dark_when_idle", 32'(bus.o_led), 32'd0);
      if (prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_end", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("pulses", pulses, cur.pulses);
          chk("busy_len", busy_len, cur.busy_len);
          chk("led_hi_cycles", hi_cycles, cur.hi_cycles);
        end
        seq_done++;
        idle_len = 1;
      end else begin
        idle_len++;
      end
    end
    prev_busy = bus.o_seq_busy;
    prev_led  = bus.o_led;
  end

  task automatic wait_done(input int target);
    for (int c = 0; c < 3000 && seq_done < target; c++) begin
      @(negedge clk);
      #1;
    end
    chk("wait_done_timeout", 32'(seq_done >= target), 32'd1);
  endtask

  task automatic wait_rise();
    for (int c = 0; c < 200 && !bus.o_seq_busy; c++) begin
      @(negedge clk);
      #1;
    end
    chk("wait_grant_timeout", 32'(bus.o_seq_busy), 32'd1);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    seq_done = 0;
    rst_n    = 1'b0;
    bus.iv_status_req = 4'b0000;
    bus.i_led_en      = 1'b0;
    #1;
    chk("reset_led", 32'(bus.o_led), 32'd0);
    chk("reset_busy", 32'(bus.o_seq_busy), 32'd0);
    chk("reset_src", 32'(bus.ov_cur_src), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Test 1: source 0 held, code repeats with one IDLE cycle between.
    exp_q.push_back(code(0, -1));
    exp_q.push_back(code(0, 1));
    bus.iv_status_req = 4'b0001;
    bus.i_led_en      = 1'b1;
    wait_done(2);
    bus.iv_status_req = 4'b0000;

    // Test 2: source 3 gives four pulses.
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(code(3, -1));
    bus.iv_status_req = 4'b1000;
    wait_done(3);
    bus.iv_status_req = 4'b0000;

    // Test 3: sources 0 and 2 alternate.
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(code(0, -1));
    exp_q.push_back(code(2, 1));
    exp_q.push_back(code(0, 1));
    exp_q.push_back(code(2, 1));
    bus.iv_status_req = 4'b0101;
    wait_done(7);
    bus.iv_status_req = 4'b0000;

    // Test 4: source 2 twice, second aborted in its 2nd ON; waiting source 0 wins next.
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(code(2, -1));
    exp_q.push_back(cut(2, 2, 9, 5, 1));
    bus.iv_status_req = 4'b0100;
    wait_done(8);
    wait_rise();
    repeat (8) @(negedge clk);
    #1;
    bus.iv_status_req = 4'b0101;
    bus.i_led_en      = 1'b0;
    @(posedge clk);
    #1;
    chk("disable_led", 32'(bus.o_led), 32'd0);
    chk("disable_busy", 32'(bus.o_seq_busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(code(0, -1));
    bus.i_led_en = 1'b1;
    wait_done(10);
    bus.iv_status_req = 4'b0000;

    // Test 5: asynchronous reset in GAP, then all four request, source 0 first.
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(cut(0, 1, 12, 4, -1));
    bus.iv_status_req = 4'b0001;
    wait_rise();
    repeat (11) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(bus.o_led), 32'd0);
    chk("async_rst_busy", 32'(bus.o_seq_busy), 32'd0);
    chk("async_rst_src", 32'(bus.ov_cur_src), 32'd0);
    bus.iv_status_req = 4'b1111;
    repeat (2) @(negedge clk);
    exp_q.push_back(code(0, -1));
    rst_n = 1'b1;
    #1;
    wait_done(12);
    bus.iv_status_req = 4'b0000;

    // Test 6: source 2 request drops during the first OFF; full code still runs.
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(code(2, -1));
    bus.iv_status_req = 4'b0100;
    wait_rise();
    repeat (5) @(negedge clk);
    #1;
    bus.iv_status_req = 4'b0000;
    wait_done(13);
    repeat (6) @(negedge clk);
    #1;
    chk("quiet_after_drop", 32'(bus.o_seq_busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_status_sequencer.md
LED_STATUS_SEQUENCER -- requirements
Module: led_status_sequencer

Interface
REQ-001 The module SHALL have parameter BLINK_TIME, default 32'd12_500_000, giving the LED on and off half-period in i_clk cycles.
REQ-002 The module SHALL have parameter GAP_TIME, default 32'd62_500_000, giving the dark gap after each blink code in i_clk cycles.
REQ-003 The module SHALL have port i_clk, input, 1 bit: system clock.
REQ-004 The module SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port iv_status_req, input, 4 bits: level status requests, bit k = source k; source 0 is the reset/clock-check indicator.
REQ-006 The module SHALL have port i_led_en, input, 1 bit: sequencer enable.
REQ-007 The module SHALL have port o_led, output, 1 bit: shared LED drive, 1 = lit.
REQ-008 The module SHALL have port ov_cur_src, output, 2 bits: index of the source currently being signalled.
REQ-009 The module SHALL have port o_seq_busy, output, 1 bit: 1 while a blink code or its gap is in progress.

Function
REQ-010 The module SHALL implement states IDLE, ON, OFF and GAP, with a 32-bit time counter, a 3-bit blink counter and a 2-bit round-robin pointer rr_last.
REQ-011 In IDLE, o_led SHALL be 0 and o_seq_busy SHALL be 0.
REQ-012 In IDLE with i_led_en=1 and any iv_status_req bit set, the module SHALL grant the first set bit searching rr_last+1, rr_last+2, ... modulo 4.
REQ-013 On a grant, the module SHALL latch the granted index into ov_cur_src, clear both counters, drive o_led=1 and o_seq_busy=1, and enter ON; o_led SHALL rise on the clock edge after the cycle in which the request is sampled.
REQ-014 In ON, the time counter SHALL increment each cycle; at count BLINK_TIME-1 the module SHALL clear the counter, drive o_led=0 and enter OFF.
REQ-015 In OFF, at count BLINK_TIME-1 the module SHALL clear the counter and increment the blink counter.
REQ-016 At the end of OFF, if the pre-increment blink counter equals ov_cur_src, the module SHALL enter GAP; otherwise it SHALL drive o_led=1 and re-enter ON, so source k produces exactly k+1 pulses.
REQ-017 In GAP, o_led SHALL be 0; at count GAP_TIME-1 the module SHALL load rr_last with ov_cur_src, clear o_seq_busy and enter IDLE.
REQ-018 The module SHALL re-arbitrate only in IDLE, so each completed sequence costs one IDLE cycle.
REQ-019 A request deasserting mid-sequence SHALL NOT alter the sequence in progress, because the source index is latched at grant.
REQ-020 A request asserting mid-sequence SHALL be considered at the next IDLE.
REQ-021 If i_led_en=0 in any non-IDLE state, the module SHALL, on the next edge, enter IDLE with o_led=0, o_seq_busy=0, counters cleared and rr_last unchanged.
REQ-022 Simultaneous requests SHALL be served strictly round-robin, with no source granted twice while another set request waits.
REQ-023 Counter comparisons SHALL be 32-bit equality; the time counter SHALL never exceed the active limit minus 1.
REQ-024 Any illegal state encoding SHALL return the module to IDLE with reset output values.

Reset
REQ-025 While i_rst_n=0, the module SHALL hold: state=IDLE, o_led=0, o_seq_busy=0, ov_cur_src=2'd0, time counter=0, blink counter=0, rr_last=2'd3 (so the first search starts at source 0).
REQ-026 Assertion of i_rst_n mid-sequence SHALL abort the sequence immediately and asynchronously.
REQ-027 After release of i_rst_n, the first grant SHALL occur no earlier than the first rising edge after release.

Verification (BLINK_TIME=4, GAP_TIME=8)
REQ-028 Test 1: iv_status_req=4'b0001, i_led_en=1 held -> o_led high for 4 cycles, low for 4 + 8 = 12 cycles, ov_cur_src=0, o_seq_busy high for 16 cycles, then 1 IDLE cycle, then the code repeats.
REQ-029 Test 2: iv_status_req=4'b1000 -> 4 pulses of 4 cycles high and 4 low, then an 8-cycle gap; o_seq_busy high for 40 cycles; ov_cur_src=3.
REQ-030 Test 3: iv_status_req=4'b0101 held -> sources served in order 0, 2, 0, 2 with 1, 3, 1, 3 pulses respectively.
REQ-031 Test 4: i_led_en dropped during the 2nd ON of source 2 -> next edge o_led=0, o_seq_busy=0; on re-enable, source 2 is not re-granted before a waiting source 0 (rr_last unchanged, search starts at 3, then 0).
REQ-032 Test 5: i_rst_n asserted in GAP -> o_led=0, o_seq_busy=0, ov_cur_src=0 immediately; after release with 4'b1111, the first grant is source 0.
REQ-033 Test 6: request bit cleared during OFF of a 3-pulse code -> all 3 pulses and the full gap still complete.
